// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours.
//  - fetchState_t : fetch FSM encoding (S_FETCH / S_EXEC / S_HALT)
//  - op*          : MIPS opcode constants shared with the main/ALU decoder controller
//  - *_MSB/*_LSB  : instruction field boundaries
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } fetchState_t;

    localparam logic [5:0] opRType = 6'h00;
    localparam logic [5:0] opAddi  = 6'h08;
    localparam logic [5:0] opLw    = 6'h23;
    localparam logic [5:0] opSw    = 6'h2B;
    localparam logic [5:0] opBeq   = 6'h04;
    localparam logic [5:0] opJ     = 6'h02;

    localparam int unsigned OPCODE_MSB  = 31;
    localparam int unsigned OPCODE_LSB  = 26;
    localparam int unsigned FUNCT_MSB   = 5;
    localparam int unsigned FUNCT_LSB   = 0;
    localparam int unsigned IMM_MSB     = 15;
    localparam int unsigned JIDX_MSB    = 25;
    // Jumps keep the PC bits from here upwards (the 256 MB region).
    localparam int unsigned JREGION_LSB = 28;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection.
//  pc_plus4  in   ADDR_WIDTH  address of the sequentially following instruction
//  instr     in   32          current instruction word
//  branch    in   1           Branch from the controller
//  zero      in   1           ALU zero flag
//  jump      in   1           Jump from the controller
//  next_pc   out  ADDR_WIDTH  jump target > taken branch target > pc_plus4
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc_plus4,
    input  logic [31:0]           instr,
    input  logic                  branch,
    input  logic                  zero,
    input  logic                  jump,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    logic [ADDR_WIDTH-1:0] jumpTarget;
    logic [ADDR_WIDTH-1:0] branchTarget;
    logic [ADDR_WIDTH-1:0] regionMask;
    logic [ADDR_WIDTH-1:0] jumpIndex;
    logic [ADDR_WIDTH-1:0] branchOffset;
    logic                  unusedOpBits;

    // Built as a mask rather than a slice so ADDR_WIDTH == 28 (no region bits) still works.
    assign regionMask   = {ADDR_WIDTH{1'b1}} << JREGION_LSB;
    assign jumpIndex    = {{(ADDR_WIDTH - 26){1'b0}}, instr[JIDX_MSB:0]} << 2;
    assign jumpTarget   = (pc_plus4 & regionMask) | jumpIndex;

    assign branchOffset = {{(ADDR_WIDTH - 16){instr[IMM_MSB]}}, instr[IMM_MSB:0]} << 2;
    assign branchTarget = pc_plus4 + branchOffset;

    assign unusedOpBits = ^instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jumpTarget;
        end else if (branch && zero) begin
            next_pc = branchTarget;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word per imem handshake, presents it
// to the controller/datapath for one or more (stalled) cycles, then advances the PC.
//  clk, reset                 clock, synchronous active-high reset
//  imem_req/addr/rdata/ack    instruction memory handshake (req held until ack)
//  stall                      hold the current instruction while in S_EXEC
//  branch, jump, zero         next-PC controls, sampled only in S_EXEC
//  instr, op_code, funct      instruction register and its decoded fields
//  instr_valid                high only in S_EXEC
//  pc, pc_plus4               address of instr and its successor
//  fetch_err                  sticky imem timeout flag; only reset leaves S_HALT
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_ack,
    input  logic                  stall,
    input  logic                  branch,
    input  logic                  jump,
    input  logic                  zero,
    output logic [31:0]           instr,
    output logic [5:0]            op_code,
    output logic [5:0]            funct,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  fetch_err
);

    localparam int unsigned CNT_WIDTH = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(WAIT_LIMIT - 1);

    fetchState_t           stateQ, stateD;
    logic [ADDR_WIDTH-1:0] pcQ, pcD;
    logic [31:0]           instrQ, instrD;
    logic [CNT_WIDTH-1:0]  waitCntQ, waitCntD;
    logic                  errQ, errD;
    logic [ADDR_WIDTH-1:0] nextPc;

    assign pc_plus4 = pcQ + ADDR_WIDTH'(4);

    next_pc_calc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_pc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instrQ),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (nextPc)
    );

    always_comb begin
        stateD   = stateQ;
        pcD      = pcQ;
        instrD   = instrQ;
        waitCntD = waitCntQ;
        errD     = errQ;
        unique case (stateQ)
            S_FETCH: begin
                if (imem_ack) begin
                    instrD = imem_rdata;
                    stateD = S_EXEC;
                end else if (waitCntQ == LAST_WAIT) begin
                    // This was the WAIT_LIMIT-th cycle without an ack.
                    errD   = 1'b1;
                    stateD = S_HALT;
                end else begin
                    waitCntD = waitCntQ + CNT_WIDTH'(1);
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    pcD      = nextPc;
                    waitCntD = '0;
                    stateD   = S_FETCH;
                end
            end
            S_HALT: begin
                errD = 1'b1;
            end
            default: begin
                stateD = S_HALT;
                errD   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= S_FETCH;
            pcQ      <= RESET_PC;
            instrQ   <= '0;
            waitCntQ <= '0;
            errQ     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            pcQ      <= pcD;
            instrQ   <= instrD;
            waitCntQ <= waitCntD;
            errQ     <= errD;
        end
    end

    // Reset masks the request in its own cycle so an in-flight fetch is dropped at once.
    assign imem_req    = (stateQ == S_FETCH) && !reset;
    assign imem_addr   = pcQ;
    assign instr       = instrQ;
    assign op_code     = instrQ[OPCODE_MSB:OPCODE_LSB];
    assign funct       = instrQ[FUNCT_MSB:FUNCT_LSB];
    assign instr_valid = (stateQ == S_EXEC);
    assign pc          = pcQ;
    assign fetch_err   = errQ;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Two instances share all inputs: one resets to
// 0, the other to 0x8000_0000 so jump-region behaviour can be observed at a high PC.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned WL = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_rdata;
    logic        imem_ack, stall, branch, jump, zero;

    logic        req, valid, err;
    logic [31:0] addr, instr, pc, pc4;
    logic [5:0]  opc, fn;

    logic        hReq, hValid, hErr;
    logic [31:0] hAddr, hInstr, hPc, hPc4;
    logic [5:0]  hOpc, hFn;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .WAIT_LIMIT(WL)) u_dut (
        .clk(clk), .reset(reset), .imem_req(req), .imem_addr(addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .stall(stall), .branch(branch), .jump(jump), .zero(zero),
        .instr(instr), .op_code(opc), .funct(fn), .instr_valid(valid), .pc(pc),
        .pc_plus4(pc4), .fetch_err(err)
    );

    instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h8000_0000), .WAIT_LIMIT(WL)) u_dut_hi (
        .clk(clk), .reset(reset), .imem_req(hReq), .imem_addr(hAddr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .stall(stall), .branch(branch), .jump(jump), .zero(zero),
        .instr(hInstr), .op_code(hOpc), .funct(hFn), .instr_valid(hValid), .pc(hPc),
        .pc_plus4(hPc4), .fetch_err(hErr)
    );

    int passCnt = 0;
    int totalCnt = 0;
    logic [31:0] mPc, mPcHi;

    typedef struct {
        logic [31:0] word;
        bit          br;
        bit          jp;
        bit          z;
        int          ackDelay;
        logic [31:0] expNext;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference next-PC straight from the architectural rules.
    function automatic logic [31:0] refNext(input logic [31:0] p, input logic [31:0] w,
                                            input bit br, input bit jp, input bit z);
        logic [31:0] p4;
        int          off;
        p4 = p + 32'd4;
        if (jp) return (p4 & 32'hF000_0000) + {6'b0, w[25:0]} * 32'd4;
        if (br && z) begin
            off = $signed(w[15:0]);
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    task automatic doReset();
        reset = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b0;
        #1;
        check("rst_req_same_cycle", 64'(req), 64'd0);
        tick();
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_pc_hi", 64'(hPc), 64'h8000_0000);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        #1;
        mPc = 32'h0;
        mPcHi = 32'h8000_0000;
    endtask

    // One fetch + execute. Called at a negedge while in S_FETCH. Control inputs carry junk
    // outside the final S_EXEC cycle; stall carries junk during the fetch.
    task automatic execStep(input string nm, input logic [31:0] word, input bit br,
                            input bit jp, input bit z, input int ackDelay,
                            input int stallCycles, input logic [31:0] expLo);
        check({nm, "_req"}, 64'(req), 64'd1);
        check({nm, "_addr"}, 64'(addr), 64'(mPc));
        for (int d = 0; d < ackDelay; d++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            {branch, jump, zero, stall} = 4'($urandom);
            tick();
            check({nm, "_wait_valid"}, 64'(valid), 64'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'($urandom);
        imem_rdata = $urandom;
        check({nm, "_valid"}, 64'(valid), 64'd1);
        check({nm, "_req_exec"}, 64'(req), 64'd0);
        check({nm, "_instr"}, 64'(instr), 64'(word));
        check({nm, "_opcode"}, 64'(opc), 64'(word[31:26]));
        check({nm, "_funct"}, 64'(fn), 64'(word[5:0]));
        check({nm, "_pc"}, 64'(pc), 64'(mPc));
        check({nm, "_pc4"}, 64'(pc4), 64'(mPc + 32'd4));
        for (int s = 0; s < stallCycles; s++) begin
            stall = 1'b1;
            {branch, jump, zero} = 3'($urandom);
            tick();
            check({nm, "_stall_valid"}, 64'(valid), 64'd1);
            check({nm, "_stall_pc"}, 64'(pc), 64'(mPc));
            check({nm, "_stall_instr"}, 64'(instr), 64'(word));
        end
        stall = 1'b0;
        branch = br;
        jump = jp;
        zero = z;
        tick();
        imem_ack = 1'b0;
        mPc = expLo;
        mPcHi = refNext(mPcHi, word, br, jp, z);
        check({nm, "_next_pc"}, 64'(pc), 64'(mPc));
        check({nm, "_next_pc_hi"}, 64'(hPc), 64'(mPcHi));
        check({nm, "_after_valid"}, 64'(valid), 64'd0);
        check({nm, "_err"}, 64'(err), 64'd0);
    endtask

    vec_t vecs[13];

    initial begin
        logic [31:0] w;
        bit          br, jp, z;

        reset = 1'b1;
        {imem_ack, stall, branch, jump, zero} = '0;
        imem_rdata = '0;
        @(negedge clk);

        vecs[0]  = '{32'h0022_1820, 0, 0, 0, 1, 32'h0000_0004};  // add
        vecs[1]  = '{32'h2001_0005, 0, 0, 0, 1, 32'h0000_0008};  // addi
        vecs[2]  = '{32'h8C22_0000, 0, 0, 0, 1, 32'h0000_000C};  // lw
        vecs[3]  = '{32'hAC22_0004, 0, 0, 0, 1, 32'h0000_0010};  // sw
        vecs[4]  = '{32'h1000_FFFE, 1, 0, 1, 0, 32'h0000_000C};  // beq taken, -2 words
        vecs[5]  = '{32'hAC22_0004, 0, 0, 0, 2, 32'h0000_0010};
        vecs[6]  = '{32'h1000_FFFE, 1, 0, 0, 0, 32'h0000_0014};  // beq not taken
        vecs[7]  = '{32'h0800_0040, 0, 1, 0, 1, 32'h0000_0100};  // j 0x40
        vecs[8]  = '{32'h0800_0010, 1, 1, 1, 0, 32'h0000_0040};  // jump beats branch
        vecs[9]  = '{32'h1000_0003, 1, 0, 1, 3, 32'h0000_0050};
        vecs[10] = '{32'h0000_7FFF, 1, 0, 1, 0, 32'h0002_0050};  // max forward offset
        vecs[11] = '{32'h0022_1820, 0, 0, 0, WL - 1, 32'h0002_0054};  // ack on last cycle
        vecs[12] = '{32'h1000_8000, 1, 0, 1, 0, 32'h0000_0058};  // max backward offset

        doReset();
        for (int i = 0; i < 13; i++) begin
            execStep($sformatf("vec%0d", i), vecs[i].word, vecs[i].br, vecs[i].jp, vecs[i].z,
                     vecs[i].ackDelay, 0, vecs[i].expNext);
        end

        // Jump at a high PC keeps the upper region bits.
        doReset();
        execStep("jhi", {opJ, 26'h000_0040}, 0, 1, 0, 1, 0, 32'h0000_0100);
        check("jhi_abs", 64'(hPc), 64'h8000_0100);
        execStep("jhi_prio", {opJ, 26'h000_0040}, 1, 1, 1, 0, 0, 32'h0000_0100);
        check("jhi_prio_abs", 64'(hPc), 64'h8000_0100);

        // Three stalled cycles, then advance.
        execStep("stall3", {opRType, 26'h22_1820}, 0, 0, 0, 1, 3, mPc + 32'd4);

        // Randomized sequence against the reference model.
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            jp = ($urandom_range(0, 3) == 0);
            br = 1'($urandom);
            z = 1'($urandom);
            execStep($sformatf("rnd%0d", i), w, br, jp, z, $urandom_range(0, 4),
                     $urandom_range(0, 2), refNext(mPc, w, br, jp, z));
        end

        // Timeout: no ack for WAIT_LIMIT cycles.
        doReset();
        imem_ack = 1'b0;
        for (int c = 0; c < int'(WL) - 1; c++) tick();
        check("to_err_before", 64'(err), 64'd0);
        check("to_req_before", 64'(req), 64'd1);
        tick();
        check("to_err", 64'(err), 64'd1);
        check("to_req_halt", 64'(req), 64'd0);
        for (int c = 0; c < 6; c++) begin
            imem_ack = 1'($urandom);
            stall = 1'($urandom);
            tick();
        end
        check("to_err_sticky", 64'(err), 64'd1);
        check("to_valid_halt", 64'(valid), 64'd0);
        check("to_req_sticky", 64'(req), 64'd0);
        doReset();
        check("to_restart_req", 64'(req), 64'd1);
        check("to_restart_addr", 64'(addr), 64'd0);

        // Reset mid-fetch with an ack arriving in the same cycle.
        execStep("pre_rst", {opAddi, 26'h1_0005}, 0, 0, 0, 0, 0, 32'h4);
        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        doReset();
        check("rstf_instr", 64'(instr), 64'd0);

        // Reset mid-exec.
        imem_ack = 1'b1;
        imem_rdata = {opLw, 26'h22_0000};
        tick();
        imem_ack = 1'b0;
        stall = 1'b1;
        check("rste_valid_pre", 64'(valid), 64'd1);
        doReset();
        check("rste_addr", 64'(addr), 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
